// File: rtl/uart_tx.sv
// uart_tx: LSB-first UART transmitter at CLKDIV clocks per bit (8N1).
// Define UART_TX_PARITY_EN to insert an even parity bit after data bit 7 (8E1).
module uart_tx #(
   parameter int CLKDIV = 128
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] txdata,
   input  logic       txvalid,
   output logic       txready,
   output logic       tx_pin,
   output logic       busy
);

   localparam int            CW     = $clog2(CLKDIV);
   localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bitcnt_q, bitcnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_d;
   logic          txready_d;
   logic          bit_end;
`ifdef UART_TX_PARITY_EN
   logic          par_q, par_d;
`endif

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
      par_d    = par_q;
`endif
      bit_end  = (cnt_q == '0);

      if (state_q != IDLE)
         cnt_d = bit_end ? RELOAD : cnt_q - 1'b1;

      case (state_q)
         IDLE: begin
            if (txready && txvalid) begin
               state_d = START;
               shift_d = txdata;
               cnt_d   = RELOAD;
`ifdef UART_TX_PARITY_EN
               par_d   = ^txdata;
`endif
            end
         end
         START: begin
            if (bit_end) begin
               state_d  = DATA;
               bitcnt_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d  = shift_q >> 1;
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end)
               state_d = STOP;
         end
`endif
         STOP: begin
            if (bit_end)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Line level is decoded from the next state so tx_pin can be a flop.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = 1'b1;
      endcase

      txready_d = (state_d == IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         shift_q  <= '0;
         tx_pin   <= 1'b1;
         txready  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         tx_pin   <= tx_d;
         txready  <= txready_d;
`ifdef UART_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO-model source, byte scoreboard and a
// cycle-exact line checker. Works with or without UART_TX_PARITY_EN.
module tb_uart_tx;

   localparam int CLKDIV = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CLKDIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] txdata = 8'h00;
   logic       txvalid = 1'b0;
   logic       txready, tx_pin, busy;

   int checks = 0;
   int failures = 0;

   byte unsigned src_q[$];     // FIFO model feeding the DUT
   byte unsigned sb_q[$];      // expected bytes, in send order
   int unsigned  accept_t[$];  // clock edge index of each accept
   int unsigned  cyc = 0;

   uart_tx #(.CLKDIV(CLKDIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .txdata  (txdata),
      .txvalid (txvalid),
      .txready (txready),
      .tx_pin  (tx_pin),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // FIFO read port: presents the head byte, pops it the negedge after an accept.
   initial begin : fifo_drv
      bit will_accept;
      will_accept = 1'b0;
      forever begin
         @(negedge clk);
         if (will_accept)
            void'(src_q.pop_front());
         txvalid = (src_q.size() != 0);
         txdata  = txvalid ? src_q[0] : 8'h00;
         #1;
         will_accept = txready && txvalid && !rst;
         if (will_accept)
            accept_t.push_back(cyc + 1);
      end
   end

   task automatic send(input byte unsigned b);
      src_q.push_back(b);
      sb_q.push_back(b);
   endtask

   task automatic wait_start(input int limit);
      int waited;
      waited = 0;
      while (tx_pin !== 1'b0 && waited < limit) begin
         @(negedge clk);
         waited++;
      end
   endtask

   // Sample every cycle of one frame and compare against the expected waveform.
   task automatic expect_frame(input string tag, output int unsigned t_acc);
      byte unsigned     b;
      logic [NBITS-1:0] bits;
      logic [63:0]      exp_line, obs_line, obs_rdy, obs_busy, exp_busy;
      t_acc = 0;
      wait_start(4 * FRAME);
      check({tag, " start_bit"}, {63'b0, tx_pin}, 64'd0);
      if (tx_pin !== 1'b0)
         return;
      check({tag, " pending"}, {63'b0, (sb_q.size() != 0 && accept_t.size() != 0)}, 64'd1);
      if (sb_q.size() == 0 || accept_t.size() == 0)
         return;
      b     = sb_q.pop_front();
      t_acc = accept_t.pop_front();
      check({tag, " latency"}, 64'(cyc), 64'(t_acc));
`ifdef UART_TX_PARITY_EN
      bits = {1'b1, ^b, b, 1'b0};
`else
      bits = {1'b1, b, 1'b0};
`endif
      exp_line = '0;
      exp_busy = '0;
      obs_line = '0;
      obs_rdy  = '0;
      obs_busy = '0;
      for (int i = 0; i < FRAME; i++) begin
         exp_line[i] = bits[i / CLKDIV];
         exp_busy[i] = 1'b1;
         obs_line[i] = tx_pin;
         obs_rdy[i]  = txready;
         obs_busy[i] = busy;
         @(negedge clk);
      end
      check({tag, " line"}, obs_line, exp_line);
      check({tag, " txready_low"}, obs_rdy, 64'd0);
      check({tag, " busy_high"}, obs_busy, exp_busy);
      check({tag, " idle_gap"}, {61'b0, tx_pin, txready, busy}, 64'b110);
   endtask

   initial begin : main
      int unsigned t0, t1;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {61'b0, tx_pin, txready, busy}, 64'b100);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", {61'b0, tx_pin, txready, busy}, 64'b110);

      send(8'hA5);
      expect_frame("basic_a5", t0);

      send(8'h00);
      send(8'hFF);
      expect_frame("b2b_00", t0);
      expect_frame("b2b_ff", t1);
      check("b2b_spacing", 64'(t1 - t0), 64'(FRAME + 1));

      // 0xFF waits at the FIFO head with txvalid high for the whole 0x3C frame.
      send(8'h3C);
      send(8'hFF);
      expect_frame("stab_3c", t0);
      expect_frame("stab_ff", t1);
      check("stab_spacing", 64'(t1 - t0), 64'(FRAME + 1));

      send(8'h00);
      wait_start(4 * FRAME);
      check("rst_frame_started", {63'b0, tx_pin}, 64'd0);
      repeat (4 * CLKDIV + 1) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_abort", {61'b0, tx_pin, txready, busy}, 64'b100);
      @(negedge clk);
      check("rst_ready_again", {61'b0, tx_pin, txready, busy}, 64'b110);
      if (sb_q.size() != 0)
         void'(sb_q.pop_front());
      if (accept_t.size() != 0)
         void'(accept_t.pop_front());
      send(8'h55);
      expect_frame("after_rst_55", t0);

`ifdef UART_TX_PARITY_EN
      send(8'h07);
      send(8'h03);
      expect_frame("par_07", t0);
      expect_frame("par_03", t1);
      check("par_spacing", 64'(t1 - t0), 64'(FRAME + 1));
`endif

      for (int i = 0; i < 256; i++)
         send(8'(i));
      expect_frame("loop_0", t0);
      for (int i = 1; i < 256; i++) begin
         expect_frame($sformatf("loop_%0d", i), t1);
         check($sformatf("loop_spacing_%0d", i), 64'(t1 - t0), 64'(FRAME + 1));
         t0 = t1;
      end

      check("queues_drained", 64'(sb_q.size() + src_q.size() + accept_t.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
